muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the five-stage pipeline's EX stage. It implements unsigned MUL, MULHU, DIVU and REMU as 32-step shift-add and restoring-divide loops. It does no arithmetic of its own: each step borrows the shared EX-stage ALU through a request/mux interface, issuing only `ADD` and `SUB` and reading back the ALU result. The pipeline is stalled via `busy` until `done`.

---
 rtl/muldiv_seq.sv | 145 ++++++++++++++
 tb/tb_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared EX-stage ALU one step per cycle.
// Build option: define MULDIV_DIV_EN to include the restoring-divide datapath.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_CTRL_WIDTH
`define ALU_CTRL_WIDTH 4
`endif
`ifndef ADD
`define ADD 4'b0010
`endif
`ifndef SUB
`define SUB 4'b0110
`endif

module muldiv_seq #(
    parameter int WIDTH = `CPU_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           src1,
    input  logic [WIDTH-1:0]           src2,
    input  logic                       flush,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       alu_req,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [`ALU_CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]           alu_res
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    // acc holds P_hi / R, lo holds P_lo / Q, opb holds M / D
    logic [WIDTH-1:0] acc, lo, opb;
    logic [WIDTH-1:0] acc_n, lo_n;
    logic             carry;
    logic             accept;

    assign busy    = (state == S_ITER);
    assign done    = (state == S_DONE);
    assign alu_req = (state == S_ITER);
    assign accept  = start && !flush && (state == S_IDLE || state == S_DONE);

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = `ADD;
        if (state == S_ITER) begin
`ifdef MULDIV_DIV_EN
            if (op_r[1]) begin
                alu_a    = {acc[WIDTH-2:0], lo[WIDTH-1]};
                alu_b    = opb;
                alu_ctrl = `SUB;
            end else begin
                alu_a = acc;
                alu_b = lo[0] ? opb : '0;
            end
`else
            alu_a = acc;
            alu_b = lo[0] ? opb : '0;
`endif
        end
    end

    assign carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                   ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_res[WIDTH-1]);

`ifdef MULDIV_DIV_EN
    logic borrow, qbit;
    assign borrow = (~alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                    (~(alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) & alu_res[WIDTH-1]);
    // the bit shifted out of R counts as an extra dividend msb
    assign qbit   = acc[WIDTH-1] | ~borrow;

    always_comb begin
        if (op_r[1]) begin
            acc_n = qbit ? alu_res : alu_a;
            lo_n  = {lo[WIDTH-2:0], qbit};
        end else begin
            acc_n = {carry, alu_res[WIDTH-1:1]};
            lo_n  = {alu_res[0], lo[WIDTH-1:1]};
        end
    end
`else
    assign acc_n = {carry, alu_res[WIDTH-1:1]};
    assign lo_n  = {alu_res[0], lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_r   <= 2'b00;
            acc    <= '0;
            lo     <= '0;
            opb    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            op_r <= op;
            cnt  <= '0;
            acc  <= '0;
            if (op[1]) begin
`ifdef MULDIV_DIV_EN
                lo  <= src1;
                opb <= src2;
                if (src2 == '0) begin
                    result <= op[0] ? src1 : '1;
                    state  <= S_DONE;
                end else begin
                    state <= S_ITER;
                end
`else
                result <= '0;
                state  <= S_DONE;
`endif
            end else begin
                lo    <= src2;
                opb   <= src1;
                state <= S_ITER;
            end
        end else if (state == S_ITER) begin
            acc <= acc_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                result <= op_r[0] ? acc_n : lo_n;
                state  <= S_DONE;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq; the ALU is modelled as a combinational add/sub.
`ifndef ALU_CTRL_WIDTH
`define ALU_CTRL_WIDTH 4
`endif
`ifndef ADD
`define ADD 4'b0010
`endif
`ifndef SUB
`define SUB 4'b0110
`endif

module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [1:0]  op;
    logic [31:0] src1, src2, result, alu_a, alu_b, alu_res;
    logic        busy, done, alu_req;
    logic [`ALU_CTRL_WIDTH-1:0] alu_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign alu_res = (alu_ctrl == `SUB) ? alu_a - alu_b : alu_a + alu_b;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .busy(busy), .done(done), .result(result), .alu_req(alu_req),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output int rcnt, output logic seen);
        res = '0; lat = 0; bcnt = 0; rcnt = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (alu_req) rcnt++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                res  = result;
            end
        end
    endtask

    logic [31:0] r;
    int lat, bc, rc, dcnt;
    logic seen;
`ifdef MULDIV_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif
    localparam int DLAT = DIV ? 33 : 1;

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst alu_req", alu_req, 0);
        chk("rst result", result, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_ctrl", alu_ctrl, `ADD);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, r, lat, bc, rc, seen);
        chk("mul7x6 seen", seen, 1);
        chk("mul7x6 result", r, 42);
        chk("mul7x6 latency", lat, 33);
        chk("mul7x6 busy cycles", bc, 32);
        chk("mul7x6 alu_req cycles", rc, 32);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, rc, seen);
        chk("mulhu ff seen", seen, 1);
        chk("mulhu ff result", r, 32'hFFFF_FFFE);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, rc, seen);
        chk("mul ff result", r, 32'h1);

        run_op(2'b10, 32'd100, 32'd7, r, lat, bc, rc, seen);
        chk("divu 100/7 result", r, DIV ? 32'd14 : 32'd0);
        chk("divu 100/7 latency", lat, DLAT);
        run_op(2'b11, 32'd100, 32'd7, r, lat, bc, rc, seen);
        chk("remu 100/7 result", r, DIV ? 32'd2 : 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, rc, seen);
        chk("divu msb result", r, 32'd0);
        chk("divu msb latency", lat, DLAT);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, rc, seen);
        chk("remu msb result", r, DIV ? 32'h8000_0000 : 32'd0);

        run_op(2'b10, 32'd5, 32'd0, r, lat, bc, rc, seen);
        chk("divu 5/0 result", r, DIV ? 32'hFFFF_FFFF : 32'd0);
        chk("divu 5/0 latency", lat, 1);
        chk("divu 5/0 busy cycles", bc, 0);
        run_op(2'b11, 32'd5, 32'd0, r, lat, bc, rc, seen);
        chk("remu 5/0 result", r, DIV ? 32'd5 : 32'd0);
        chk("remu 5/0 alu_req cycles", rc, 0);

        // flush mid-ITER keeps the previous result
        run_op(2'b00, 32'd7, 32'd6, r, lat, bc, rc, seen);
        chk("pre-flush result", r, 42);
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("flush no done", dcnt, 0);
        chk("flush result held", result, 42);

        start = 1'b1; flush = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("start+flush busy", busy, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("start+flush no done", dcnt, 0);

        // starts during ITER must not disturb the running multiply
        start = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0; r = '0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                r = result;
            end
            if (i == 5 || i == 12 || i == 20) begin
                start = 1'b1; src1 = 32'd2; src2 = 32'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ignored start done count", dcnt, 1);
        chk("ignored start result", r, 81);

        @(negedge clk);
        start = 1'b1; op = 2'b01; src1 = 32'hFFFF_FFFF; src2 = 32'h1234_5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst alu_req", alu_req, 0);
        chk("async rst result", result, 0);
        chk("async rst alu_a", alu_a, 0);
        chk("async rst alu_b", alu_b, 0);
        chk("async rst alu_ctrl", alu_ctrl, `ADD);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd3, 32'd4, r, lat, bc, rc, seen);
        chk("post-reset mul3x4 seen", seen, 1);
        chk("post-reset mul3x4 result", r, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
